// File: rtl/prbs_checker_if.sv
// prbs_checker_if: control inputs and status outputs of the PRBS checker
interface prbs_checker_if #(parameter int CNT_W = 32);
  logic rst_prbs;
  logic en;
  logic din;
  logic din_valid;
  logic locked;
  logic err_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic cnt_sat;
  modport master (output rst_prbs, en, din, din_valid, input locked, err_pulse, err_cnt, bit_cnt, cnt_sat);
  modport slave (input rst_prbs, en, din, din_valid, output locked, err_pulse, err_cnt, bit_cnt, cnt_sat);
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS receiver with lock detection and saturating error/bit counters
module prbs_checker #(
  parameter int PRBS_ORDER = 7,
  parameter int LOCK_THRESH = 32,
  parameter int WIN_LEN = 64,
  parameter int LOSS_ERRS = 8,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  prbs_checker_if.slave bus
);
  localparam int TAP = PRBS_ORDER == 7 ? 6 : PRBS_ORDER == 15 ? 14 : PRBS_ORDER == 23 ? 18 : 28;
  localparam int SW = $clog2(PRBS_ORDER + 1);
  localparam int MW = $clog2(LOCK_THRESH + 1);
  localparam int WW = $clog2(WIN_LEN);
  localparam int EW = $clog2(LOSS_ERRS + 1);
  typedef enum logic [1:0] {IDLE, SEED, VERIFY, LOCKED} state_t;
  state_t state;
  logic [PRBS_ORDER-1:0] s;
  logic [SW-1:0] seed_cnt;
  logic [MW-1:0] match_cnt;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] win_err, win_err_n;
  logic [CNT_W-1:0] err_n, bit_n;
  logic p, mis, win_last, seed_last;
  assign p = s[PRBS_ORDER-1] ^ s[TAP-1];
  assign mis = bus.din != p;
  assign win_err_n = win_err + EW'(mis);
  assign win_last = win_cnt == WW'(WIN_LEN - 1);
  assign seed_last = seed_cnt == SW'(PRBS_ORDER - 1);
  assign bit_n = &bus.bit_cnt ? bus.bit_cnt : bus.bit_cnt + CNT_W'(1);
  assign err_n = (&bus.err_cnt || !mis) ? bus.err_cnt : bus.err_cnt + CNT_W'(1);
  // en=0 during reset is resolved on the next edge, where IDLE is forced anyway
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
      s <= '0;
      seed_cnt <= '0;
      match_cnt <= '0;
      win_cnt <= '0;
      win_err <= '0;
      bus.locked <= 1'b0;
      bus.err_pulse <= 1'b0;
      bus.err_cnt <= '0;
      bus.bit_cnt <= '0;
      bus.cnt_sat <= 1'b0;
    end else if (bus.rst_prbs) begin
      state <= bus.en ? SEED : IDLE;
      s <= '0;
      seed_cnt <= '0;
      match_cnt <= '0;
      win_cnt <= '0;
      win_err <= '0;
      bus.locked <= 1'b0;
      bus.err_pulse <= 1'b0;
      bus.err_cnt <= '0;
      bus.bit_cnt <= '0;
      bus.cnt_sat <= 1'b0;
    end else begin
      bus.err_pulse <= 1'b0;
      if (!bus.en) begin
        state <= IDLE;
        seed_cnt <= '0;
        match_cnt <= '0;
        win_cnt <= '0;
        win_err <= '0;
        bus.locked <= 1'b0;
      end else if (bus.din_valid) begin
        if (state == IDLE || state == SEED) begin
          s <= {s[PRBS_ORDER-2:0], bus.din};
          seed_cnt <= seed_last ? '0 : seed_cnt + SW'(1);
          state <= seed_last ? VERIFY : SEED;
        end else if (state == VERIFY) begin
          s <= {s[PRBS_ORDER-2:0], bus.din};
          // an all-zero register predicts zeros forever, so it must never count as a match
          if (mis || s == '0) begin
            state <= SEED;
            match_cnt <= '0;
          end else if (match_cnt == MW'(LOCK_THRESH - 1)) begin
            state <= LOCKED;
            match_cnt <= '0;
            bus.locked <= 1'b1;
          end else begin
            match_cnt <= match_cnt + MW'(1);
          end
        end else begin
          // free-running prediction so one flipped bit is counted once, not once per tap
          s <= {s[PRBS_ORDER-2:0], p};
          bus.bit_cnt <= bit_n;
          bus.err_cnt <= err_n;
          bus.err_pulse <= mis;
          if (&bit_n || &err_n) bus.cnt_sat <= 1'b1;
          if (win_err_n == EW'(LOSS_ERRS)) begin
            state <= SEED;
            bus.locked <= 1'b0;
            win_cnt <= '0;
            win_err <= '0;
          end else begin
            win_cnt <= win_cnt + WW'(1);
            win_err <= win_last ? '0 : win_err_n;
          end
        end
      end
    end
  end
endmodule
